// File: rtl/alarm_hub_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : alarm_hub_if
// Brief    : req/ack handshake between alarm_hub and its downstream consumer.
//            The hub is the master: it raises req with the channel index and
//            the consumer answers with a level ack.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface alarm_hub_if #(
    parameter int CH_W = 2
) ();
    logic            req;
    logic [CH_W-1:0] req_ch;
    logic            ack;

    modport master (output req, output req_ch, input ack);
    modport slave  (input req, input req_ch, output ack);
endinterface
`default_nettype wire

// File: rtl/alarm_hub.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : alarm_hub
// Brief    : N-channel alarm conditioner. Each active-low sensor is
//            synchronised, debounced and falling-edge detected into a sticky
//            latch; latched channels are offered to a consumer one at a time,
//            lowest index first, over a req/ack handshake.
// Options  : ALARM_REPEAT_EN - free-running timer re-requests every still
//            latched channel once per REPEAT_CYCLES.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module alarm_hub #(
    parameter int NUM_CH          = 3,
    parameter int CH_W            = 2,
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int CNT_W           = 18,
    parameter int REPEAT_CYCLES   = 24000000
) (
    input  wire logic              clk_24m,
    input  wire logic              rst_n,
    input  wire logic [NUM_CH-1:0] sens_n,
    input  wire logic [NUM_CH-1:0] mask,
    input  wire logic [NUM_CH-1:0] clear,
    output logic      [NUM_CH-1:0] sens_level,
    output logic      [NUM_CH-1:0] alarm_latched,
    output logic                   alarm_any,
    alarm_hub_if.master            hs
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_deb_max = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_req;
    logic              w_req_next;
    logic [CH_W-1:0]   r_req_ch;
    logic [CH_W-1:0]   w_req_ch_next;
    logic              w_take;       // consumer accepted the current request
    logic              w_wrap;       // repeat period elapsed
    logic [NUM_CH-1:0] w_reported;
    logic [NUM_CH-1:0] w_pending;
    logic [CH_W-1:0]   w_low_idx;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0]       r_sync;
        logic [CNT_W-1:0] r_cnt;
        logic             r_level;
        logic             r_level_d;
        logic             r_latched;
        logic             r_reported;
        logic             w_event;
        logic             w_take_me;

        // A new event is a registered falling edge of the stable level on an unmasked channel
        assign w_event   = r_level_d & ~r_level & ~mask[i];
        assign w_take_me = w_take && (r_req_ch == CH_W'(i));

        // Two-flop synchroniser for the asynchronous sensor input
        always_ff @(posedge clk_24m or negedge rst_n) begin
            if (!rst_n) r_sync <= 2'b11;
            else        r_sync <= {r_sync[0], sens_n[i]};
        end

        // Debounce: the stable level flips only after an unbroken run of disagreeing samples
        always_ff @(posedge clk_24m or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt   <= '0;
                r_level <= 1'b1;
            end else if (r_sync[1] == r_level) begin
                r_cnt   <= '0;
            end else if (r_cnt == c_deb_max) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end

        // Edge history, sticky alarm and reported flag; an event beats a clear and re-arms the channel
        always_ff @(posedge clk_24m or negedge rst_n) begin
            if (!rst_n) begin
                r_level_d  <= 1'b1;
                r_latched  <= 1'b0;
                r_reported <= 1'b0;
            end else begin
                r_level_d <= r_level;
                if (w_event)       r_latched <= 1'b1;
                else if (clear[i]) r_latched <= 1'b0;
                if (w_event)                 r_reported <= 1'b0;
                else if (w_take_me)          r_reported <= 1'b1;
                else if (clear[i] || w_wrap) r_reported <= 1'b0;
            end
        end

        assign sens_level[i]    = r_level;
        assign alarm_latched[i] = r_latched;
        assign w_reported[i]    = r_reported;
    end

    assign w_pending = alarm_latched & ~w_reported;
    assign alarm_any = |alarm_latched;

    // Lowest-index pending channel
    always_comb begin
        w_low_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (w_pending[k]) w_low_idx = CH_W'(k);
        end
    end

    // Handshake next state; req/req_ch are registered so they stay glitch-free
    always_comb begin
        w_state_next  = r_state;
        w_req_next    = r_req;
        w_req_ch_next = r_req_ch;
        w_take        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!hs.ack && |w_pending) begin
                    w_state_next  = REQ;
                    w_req_next    = 1'b1;
                    w_req_ch_next = w_low_idx;
                end
            end
            REQ: begin
                if (hs.ack) begin
                    w_state_next = WAIT_LOW;
                    w_req_next   = 1'b0;
                    w_take       = 1'b1;
                end
            end
            WAIT_LOW: begin
                if (!hs.ack) w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
                w_req_next   = 1'b0;
            end
        endcase
    end

    // Handshake state and output registers
    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_req    <= 1'b0;
            r_req_ch <= '0;
        end else begin
            r_state  <= w_state_next;
            r_req    <= w_req_next;
            r_req_ch <= w_req_ch_next;
        end
    end

    assign hs.req    = r_req;
    assign hs.req_ch = r_req_ch;

`ifdef ALARM_REPEAT_EN
    localparam int c_rpt_w = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [c_rpt_w-1:0] c_rpt_max = c_rpt_w'(REPEAT_CYCLES - 1);

    logic [c_rpt_w-1:0] r_timer;

    assign w_wrap = (r_timer == c_rpt_max);

    // Free-running repeat period timer
    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n)      r_timer <= '0;
        else if (w_wrap) r_timer <= '0;
        else             r_timer <= r_timer + c_rpt_w'(1);
    end
`else
    // No repeat timer: the period has no effect and each latch is requested once
    assign w_wrap = 1'b0 & (REPEAT_CYCLES == 0);
`endif

endmodule
`default_nettype wire

// File: doc/alarm_hub.md
Name: alarm_hub

Overview:
- Parametrised N-channel alarm conditioner; successor to the fixed three-sensor (fire/gas/smoke) edge detect plus OR aggregation in the top level.
- Per channel: synchronises, debounces and falling-edge detects active-low sensor inputs, then latches events until cleared.
- Serialises latched events to a downstream consumer (GSM message sender, display) through a req/ack handshake with lowest-index-first priority.

Parameters:
- NUM_CH, 3, number of sensor channels (1..16).
- CH_W, 2, width of req_ch; must satisfy 2^CH_W >= NUM_CH.
- DEBOUNCE_CYCLES, 240000, consecutive clk_24m cycles an input must disagree with its stable level before the stable level flips (10 ms); must be >= 2.
- CNT_W, 18, debounce counter width; must hold DEBOUNCE_CYCLES-1.
- REPEAT_CYCLES, 24000000, re-request period in clk_24m cycles; used only with ALARM_REPEAT_EN.

Ports:
- clk_24m  in  1  system clock, 24 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- sens_n  in  NUM_CH  raw active-low sensor inputs; asynchronous to clk_24m.
- mask  in  NUM_CH  1 = channel cannot raise new events.
- clear  in  NUM_CH  1 = clear latched alarm for that channel.
- ack  in  1  consumer acknowledge, level.
- sens_level  out  NUM_CH  debounced sensor level (1 = inactive).
- alarm_latched  out  NUM_CH  sticky per-channel alarm.
- alarm_any  out  1  OR of alarm_latched (combinational from registers).
- req  out  1  request to consumer.
- req_ch  out  CH_W  channel index being requested; valid while req=1.

Behaviour:
- Reset values: sens_level all 1; alarm_latched 0; alarm_any 0; req 0; req_ch 0. Internal state after reset: synchronisers 1, counters 0, reported bits 0, FSM IDLE.
- Synchronisation: each sens_n bit passes through a 2-flop synchroniser (sync).
- Debounce, per channel:
  - If sync == sens_level, the counter clears.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 while sync != sens_level, sens_level flips and the counter clears on the same edge.
  - Latency from an input edge: 2 + DEBOUNCE_CYCLES cycles.
  - A single agreeing cycle restarts the count (glitch rejection).
- Event: sens_level transitions 1 to 0 while mask=0. Edge detection is registered, so alarm_latched[i] sets one cycle after sens_level falls. A 0 to 1 transition is never an event.
- Latched state:
  - clear[i] resets alarm_latched[i] and reported[i].
  - Event and clear on the same cycle: the event wins and the bit stays or becomes set.
  - mask affects only new events; it never clears latched bits.
- Handshake FSM, states IDLE, REQ, WAIT_LOW:
  - IDLE: if any (alarm_latched & ~reported) is set, load req_ch with the lowest such index, set req=1 on the next edge and go to REQ. If ack=1 in IDLE, the FSM waits and does not arbitrate.
  - REQ: req and req_ch are held stable until ack=1 is sampled. On that edge: req goes 0, reported[req_ch] is set, and the FSM goes to WAIT_LOW.
  - WAIT_LOW: stay until ack=0, then return to IDLE. A held-high ack therefore acknowledges exactly one request.
  - If clear[req_ch] asserts during REQ, the request is not withdrawn. It completes on ack, and reported is then set for a channel that is not latched; that bit is harmless and clears on the next clear or event.
  - A new event on a channel already reported re-arms it: the set path also clears reported[i].
- Boundaries:
  - Multiple simultaneous events: all latch; requests are served in ascending index order, one per handshake.
  - rst_n asserted mid-handshake: req drops asynchronously and all latches clear.
  - A sensor held low through reset produces an event 2 + DEBOUNCE_CYCLES + 1 cycles after release.

Optional Feature:
- Macro ALARM_REPEAT_EN.
- Defined: a free-running timer counts to REPEAT_CYCLES-1. On wrap it clears all reported bits, so every still-latched channel is re-requested once per period until cleared. The timer resets to 0 on rst_n.
- Undefined: no timer logic; each latch produces exactly one request.

Test Plan (NUM_CH=4, DEBOUNCE_CYCLES=4, CH_W=2):
- sens_n[1] driven low and held -> sens_level[1]=0 at cycle 6 after the edge, alarm_latched[1]=1 at cycle 7, req=1 with req_ch=1 at cycle 8; alarm_any=1.
- sens_n[2] low pulse of 3 cycles -> sens_level, alarm_latched and req are unchanged.
- sens_n[0] and sens_n[3] fall on the same cycle; ack pulsed 1 cycle after each req -> req_ch=0 first, then req_ch=3; exactly two requests.
- ack held high for 10 cycles during REQ -> one request consumed; no further req until ack=0 and a new unreported latch exists.
- mask[2]=1 and sens_n[2] falls -> no latch; with alarm_latched[1]=1, clear[1] asserted on the same cycle as a new ch1 event -> alarm_latched[1] stays 1 and is re-requested.
- With ALARM_REPEAT_EN and REPEAT_CYCLES=50: latch ch1, ack, never clear -> req_ch=1 re-asserted after each timer wrap. Without the macro -> no second request.
